// File: rtl/adc_capture_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_seq_if
// Brief    : Command/config/status bundle between the register bank, the
//            capture sequencer and the ADC DDR datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_capture_seq_if #(
  parameter int CNT_W = 16
);
  logic             cmd_start;
  logic             cmd_abort;
  logic [CNT_W-1:0] cfg_burst_len;
  logic             sample_valid;
  logic             ddr_reset;
  logic             data_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic             cnt_wrap;
  logic             timeout;

  modport master (
    output cmd_start, cmd_abort, cfg_burst_len, sample_valid,
    input  ddr_reset, data_en, busy, done, sample_cnt, cnt_wrap, timeout
  );

  modport slave (
    input  cmd_start, cmd_abort, cfg_burst_len, sample_valid,
    output ddr_reset, data_en, busy, done, sample_cnt, cnt_wrap, timeout
  );
endinterface
`default_nettype wire

// File: rtl/adc_capture_seq.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_seq
// Brief    : AD9643 capture sequencer: DDR reset pulse, settle wait, then a
//            counted or continuous capture window. Optional capture watchdog
//            is enabled by defining CAPTURE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture_seq #(
  parameter int RST_CYCLES     = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic        s_axi_aclk,
  input  wire logic        s_axi_aresetn,
  adc_capture_seq_if.slave bus
);

  localparam logic [2:0] c_S_IDLE    = 3'd0;
  localparam logic [2:0] c_S_RST     = 3'd1;
  localparam logic [2:0] c_S_SETTLE  = 3'd2;
  localparam logic [2:0] c_S_CAPTURE = 3'd3;
  localparam logic [2:0] c_S_DONE    = 3'd4;

  // One phase counter serves the reset pulse, the settle wait and the watchdog.
  localparam int c_PH_MAX_RS = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int c_PH_MAX    = (TIMEOUT_CYCLES > c_PH_MAX_RS) ? TIMEOUT_CYCLES : c_PH_MAX_RS;
  localparam int c_PH_W      = $clog2(c_PH_MAX + 1);

  logic [2:0]        state_q, state_d;
  logic [c_PH_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic              to_q, to_d;
  logic              ddr_reset_q, data_en_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    to_d    = to_q;
    if ((state_q != c_S_IDLE) && bus.cmd_abort) begin
      state_d = c_S_IDLE;
    end else begin
      case (state_q)
        c_S_IDLE: begin
          if (bus.cmd_start && !bus.cmd_abort) begin
            state_d = c_S_RST;
            len_d   = bus.cfg_burst_len;
            cnt_d   = '0;
            wrap_d  = 1'b0;
            to_d    = 1'b0;
            ph_d    = c_PH_W'(RST_CYCLES - 1);
          end
        end
        c_S_RST: begin
          if (ph_q == '0) begin
            state_d = c_S_SETTLE;
            ph_d    = c_PH_W'(SETTLE_CYCLES - 1);
          end else begin
            ph_d = ph_q - 1'b1;
          end
        end
        c_S_SETTLE: begin
          if (ph_q == '0) begin
            state_d = c_S_CAPTURE;
          end else begin
            ph_d = ph_q - 1'b1;
          end
        end
        c_S_CAPTURE: begin
          if (bus.sample_valid) begin
            cnt_d = cnt_q + 1'b1;
            ph_d  = '0;
            // Only continuous mode can run the counter past all-ones.
            if ((len_q == '0) && (cnt_q == '1)) begin
              wrap_d = 1'b1;
            end
            if ((len_q != '0) && (cnt_d == len_q)) begin
              state_d = c_S_DONE;
            end
          end
`ifdef CAPTURE_TIMEOUT_EN
          else if (ph_q == c_PH_W'(TIMEOUT_CYCLES - 1)) begin
            to_d    = 1'b1;
            state_d = c_S_IDLE;
          end else begin
            ph_d = ph_q + 1'b1;
          end
`endif
        end
        c_S_DONE: state_d = c_S_IDLE;
        default:  state_d = c_S_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= c_S_IDLE;
      ph_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
      to_q        <= 1'b0;
      ddr_reset_q <= 1'b0;
      data_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      to_q        <= to_d;
      ddr_reset_q <= (state_d == c_S_RST);
      data_en_q   <= (state_d == c_S_CAPTURE);
      busy_q      <= (state_d != c_S_IDLE);
      done_q      <= (state_d == c_S_DONE);
    end
  end

  assign bus.ddr_reset  = ddr_reset_q;
  assign bus.data_en    = data_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sample_cnt = cnt_q;
  assign bus.cnt_wrap   = wrap_q;
  assign bus.timeout    = to_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_seq
// Brief    : Directed self-checking bench for adc_capture_seq with an
//            expected-count scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_seq;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int unsigned exp_q[$];

  adc_capture_seq_if #(.CNT_W(16)) bus  ();
  adc_capture_seq_if #(.CNT_W(4))  bus4 ();

  adc_capture_seq #(
    .RST_CYCLES(4), .SETTLE_CYCLES(8), .CNT_W(16), .TIMEOUT_CYCLES(32)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .bus(bus)
  );

  adc_capture_seq #(
    .RST_CYCLES(4), .SETTLE_CYCLES(8), .CNT_W(4), .TIMEOUT_CYCLES(32)
  ) dut_w4 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .bus(bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=%0d expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chkv(tag, obs, e);
    end
  endtask

  task automatic wait_en16();
    int n = 0;
    while (!bus.data_en && n < 40) begin
      step();
      n++;
    end
    chk1("wait_data_en", bus.data_en, 1'b1);
  endtask

  // Full length-16 burst with sample_valid held high; index k counts edges from the start edge.
  task automatic run_full16(input string tag);
    bus.cfg_burst_len = 16'd16;
    bus.sample_valid  = 1'b1;
    bus.cmd_start     = 1'b1;
    exp_q.push_back(16);
    step();
    bus.cmd_start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      chk1({tag, "_ddr_reset"}, bus.ddr_reset, (k <= 3));
      chk1({tag, "_data_en"},   bus.data_en,   (k >= 12 && k <= 27));
      chk1({tag, "_done"},      bus.done,      (k == 28));
      chk1({tag, "_busy"},      bus.busy,      (k <= 28));
      if (k == 28) chk_pop({tag, "_sample_cnt"}, 32'(bus.sample_cnt));
      if (k < 29) step();
    end
    bus.sample_valid = 1'b0;
    step();
    step();
    chkv({tag, "_cnt_hold"}, 32'(bus.sample_cnt), 32'd16);
    chk1({tag, "_wrap"}, bus.cnt_wrap, 1'b0);
  endtask

  initial begin
    int nv;
    logic v;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.cmd_start = 1'b0;  bus.cmd_abort = 1'b0;  bus.cfg_burst_len = '0;  bus.sample_valid = 1'b0;
    bus4.cmd_start = 1'b0; bus4.cmd_abort = 1'b0; bus4.cfg_burst_len = '0; bus4.sample_valid = 1'b0;
    step();
    step();
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_ddr_reset", bus.ddr_reset, 1'b0);
    chk1("rst_data_en", bus.data_en, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chkv("rst_cnt", 32'(bus.sample_cnt), 32'd0);
    chk1("rst_wrap", bus.cnt_wrap, 1'b0);
    chk1("rst_timeout", bus.timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Nominal length-16 burst.
    run_full16("b16");

    // Length 5, valid every third cycle, with an ignored start mid-capture.
    bus.cfg_burst_len = 16'd5;
    bus.cmd_start     = 1'b1;
    exp_q.push_back(5);
    step();
    bus.cmd_start = 1'b0;
    wait_en16();
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      v = (i % 3 == 0);
      bus.sample_valid = v;
      bus.cmd_start    = (i == 4);
      step();
      if (v) nv++;
      if (nv == 5) begin
        chk1("b5_done", bus.done, 1'b1);
        chk1("b5_data_en_low", bus.data_en, 1'b0);
        chk_pop("b5_sample_cnt", 32'(bus.sample_cnt));
        break;
      end
      chk1("b5_no_early_done", bus.done, 1'b0);
    end
    chkv("b5_valids_seen", nv, 5);
    bus.sample_valid = 1'b0;
    bus.cmd_start    = 1'b0;
    step();
    chk1("b5_busy_after", bus.busy, 1'b0);
    chk1("b5_done_after", bus.done, 1'b0);

    // Start and abort together in IDLE: dropped, status untouched.
    bus.cfg_burst_len = 16'd3;
    bus.cmd_start = 1'b1;
    bus.cmd_abort = 1'b1;
    step();
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    chk1("sa_busy", bus.busy, 1'b0);
    chkv("sa_cnt_kept", 32'(bus.sample_cnt), 32'd5);
    step();
    chk1("sa_busy2", bus.busy, 1'b0);

    // Continuous mode on the 4-bit instance: 20 valids then abort.
    bus4.cfg_burst_len = 4'd0;
    bus4.cmd_start = 1'b1;
    step();
    bus4.cmd_start = 1'b0;
    nv = 0;
    while (!bus4.data_en && nv < 40) begin
      step();
      nv++;
    end
    chk1("c4_data_en", bus4.data_en, 1'b1);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      bus4.sample_valid = 1'b1;
      step();
      nv++;
      chk1("c4_no_done", bus4.done, 1'b0);
      if (nv == 15) chk1("c4_wrap_before", bus4.cnt_wrap, 1'b0);
      if (nv == 16) chk1("c4_wrap_at", bus4.cnt_wrap, 1'b1);
    end
    bus4.sample_valid = 1'b0;
    bus4.cmd_abort = 1'b1;
    exp_q.push_back(nv % 16);
    step();
    bus4.cmd_abort = 1'b0;
    chk1("c4_abort_busy", bus4.busy, 1'b0);
    chk1("c4_abort_data_en", bus4.data_en, 1'b0);
    chk1("c4_abort_ddr_reset", bus4.ddr_reset, 1'b0);
    chk1("c4_abort_done", bus4.done, 1'b0);
    chk_pop("c4_sample_cnt", 32'(bus4.sample_cnt));
    chk1("c4_wrap_sticky", bus4.cnt_wrap, 1'b1);
    step();
    chk1("c4_done_later", bus4.done, 1'b0);
    chkv("c4_cnt_hold", 32'(bus4.sample_cnt), 32'd4);

    // Asynchronous reset mid-capture, then a full restart.
    bus.cfg_burst_len = 16'd16;
    bus.sample_valid  = 1'b1;
    bus.cmd_start     = 1'b1;
    step();
    bus.cmd_start = 1'b0;
    wait_en16();
    step();
    step();
    step();
    chkv("ar_cnt_pre", 32'(bus.sample_cnt), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk1("ar_busy", bus.busy, 1'b0);
    chk1("ar_data_en", bus.data_en, 1'b0);
    chk1("ar_ddr_reset", bus.ddr_reset, 1'b0);
    chk1("ar_done", bus.done, 1'b0);
    chkv("ar_cnt", 32'(bus.sample_cnt), 32'd0);
    bus.sample_valid = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_full16("rs16");

`ifdef CAPTURE_TIMEOUT_EN
    bus.cfg_burst_len = 16'd8;
    bus.sample_valid  = 1'b0;
    bus.cmd_start     = 1'b1;
    step();
    bus.cmd_start = 1'b0;
    wait_en16();
    for (int i = 0; i < 31; i++) begin
      step();
      chk1("wd_busy_pending", bus.busy, 1'b1);
    end
    step();
    chk1("wd_busy", bus.busy, 1'b0);
    chk1("wd_timeout", bus.timeout, 1'b1);
    chk1("wd_done", bus.done, 1'b0);
    chk1("wd_data_en", bus.data_en, 1'b0);
`else
    bus.cfg_burst_len = 16'd8;
    bus.sample_valid  = 1'b0;
    bus.cmd_start     = 1'b1;
    step();
    bus.cmd_start = 1'b0;
    wait_en16();
    for (int i = 0; i < 40; i++) step();
    chk1("nowd_busy", bus.busy, 1'b1);
    chk1("nowd_timeout", bus.timeout, 1'b0);
    bus.cmd_abort = 1'b1;
    step();
    bus.cmd_abort = 1'b0;
    chk1("nowd_abort_busy", bus.busy, 1'b0);
    chk1("nowd_abort_timeout", bus.timeout, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_capture_seq.md
# adc_capture_seq

Capture sequencer for the AD9643 LVDS receive path. On a start command it pulses the DDR interface reset, waits a settle interval, then holds the data enable high for a programmed number of valid samples, or until an abort in continuous mode. It sits between the AXI-lite register bank, which provides the command and config inputs and reads the status outputs, and the ADC DDR capture datapath, which it drives through `ddr_reset` and `data_en`.

## Interface
- `RST_CYCLES`, default 4: cycles `ddr_reset` is held high per start; must be ≥1.
- `SETTLE_CYCLES`, default 8: cycles between `ddr_reset` release and `data_en` rise; must be ≥1.
- `CNT_W`, default 16: width of burst length and sample counter.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only with `CAPTURE_TIMEOUT_EN`.

Ports:
- `s_axi_aclk`  in  1  sole clock.
- `s_axi_aresetn`  in  1  asynchronous, active-low reset.
- `cmd_start`  in  1  single-cycle start request.
- `cmd_abort`  in  1  single-cycle abort request.
- `cfg_burst_len`  in  CNT_W  samples per burst; 0 selects continuous mode. Latched on start.
- `sample_valid`  in  1  datapath strobe, one per captured sample.
- `ddr_reset`  out  1  DDR capture reset, active high.
- `data_en`  out  1  datapath capture enable.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.
- `sample_cnt`  out  CNT_W  samples accepted in the current or last burst.
- `cnt_wrap`  out  1  sticky: `sample_cnt` wrapped in continuous mode.
- `timeout`  out  1  sticky watchdog flag; tied 0 when the feature is compiled out.

## Operation
- The FSM has five states: IDLE, RST, SETTLE, CAPTURE, DONE. All outputs are registered.
- Reset values of all outputs: 0. State resets to IDLE.
- IDLE: `cmd_start` with no `cmd_abort` moves the FSM to RST. On that same edge the block:
  - latches `cfg_burst_len`;
  - clears `sample_cnt`, `cnt_wrap` and `timeout`.
- `cmd_start` outside IDLE is ignored.
- RST: `ddr_reset` is 1 for exactly RST_CYCLES cycles, then the FSM goes to SETTLE.
- SETTLE: both `ddr_reset` and `data_en` are 0 for SETTLE_CYCLES cycles, then the FSM goes to CAPTURE.
- CAPTURE: `data_en` is 1. Each cycle with `sample_valid`=1 increments `sample_cnt`.
  - Burst mode: when the accepted sample makes the count equal to the latched length, the FSM goes to DONE.
  - Continuous mode (length 0): the FSM stays in CAPTURE until abort. `sample_cnt` wraps modulo 2^CNT_W and sets `cnt_wrap`.
- `sample_valid` outside CAPTURE is ignored.
- DONE: `data_en` is 0 and `done` is 1 for one cycle, then the FSM returns to IDLE.
- `cmd_abort` in any non-IDLE state forces IDLE on the next edge. `ddr_reset` and `data_en` go to 0, `done` is not pulsed, and `sample_cnt` keeps its value.
- `cmd_start` and `cmd_abort` in the same cycle: abort wins and the start is dropped.
- Status outputs hold their values in IDLE until the next accepted start.
- Asynchronous reset mid-burst: the FSM returns to IDLE immediately and all outputs clear.

## Timing
- Start sampled at edge 0: `busy` and `ddr_reset` are 1 from edge 1.
- `ddr_reset` falls at edge 1+RST_CYCLES.
- `data_en` rises at edge 1+RST_CYCLES+SETTLE_CYCLES.
- The final sample is accepted at edge N: `data_en` falls and `done` rises at edge N+1. `done` and `busy` fall at edge N+2.
- Abort sampled at edge A: `busy`, `ddr_reset` and `data_en` are 0 from edge A+1.
- A new start is accepted the cycle after `busy` falls.
- Counter update is single-cycle. The counter can accept a sample on every cycle.

## Configuration
- Macro: `CAPTURE_TIMEOUT_EN`.
- When defined, a watchdog runs in CAPTURE:
  - it counts consecutive cycles with `sample_valid`=0 and resets on each valid;
  - when it reaches TIMEOUT_CYCLES, it sets `timeout`, forces IDLE as an abort does, and does not pulse `done`.
- When not defined: there is no watchdog logic, `timeout` is constant 0, and CAPTURE waits indefinitely.

## Test plan
- Settings RST_CYCLES=4, SETTLE_CYCLES=8, burst length 16, `sample_valid` always 1, start at edge 0:
  - `ddr_reset` is high on edges 1–4;
  - `data_en` is high on edges 13–28;
  - `done` pulses at edge 29;
  - `sample_cnt` ends at 16.
- Burst length 5 with `sample_valid` every third cycle → `done` follows the 5th valid by one cycle, and `sample_cnt` is 5.
- Continuous mode with CNT_W=4 and 20 valids, then abort → `sample_cnt`=4, `cnt_wrap`=1, no `done`, and `data_en`=0 the cycle after the abort.
- Start and abort in the same cycle in IDLE → `busy` stays 0. A start during CAPTURE → ignored; the burst completes normally.
- Deassert `s_axi_aresetn` mid-CAPTURE → all outputs 0 asynchronously. A start after release → full sequence restarts.
- With `CAPTURE_TIMEOUT_EN`, TIMEOUT_CYCLES=32, and no valids in CAPTURE → `timeout`=1 and `busy`=0 after 32 cycles, with no `done`.
